// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg: shared definitions for the tournament branch predictor resolve path.
//   - default local / global table index widths
//   - sequencer state encoding
//   - helper for the fall-through (not-taken) fetch address
// ---------------------------------------------------------------------------
package bp_pkg;

  localparam int BP_LIDX_W = 10;
  localparam int BP_GIDX_W = 12;

  typedef enum logic [1:0] {
    INIT  = 2'd0,  // walking every table index to clear it
    RUN   = 2'd1,  // accepting predictions and resolutions
    FLUSH = 2'd2   // one dead cycle after a mispredict
  } bp_state_t;

  // Address of the instruction after a 4-byte branch; wraps mod 2^32.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// ---------------------------------------------------------------------------
// bp_inflight_fifo: synchronous FIFO holding in-flight branch predictions.
//   clk, rst_n   clock / asynchronous active-low reset
//   push, din    write din at the tail when not full
//   pop          drop the head entry when not empty
//   clear        empty the queue; wins over a same-cycle push or pop
//   dout         current head entry (valid when !empty)
//   full, empty  occupancy flags derived from a separate count
// A push while full is dropped even if a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module bp_inflight_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic do_push;
  logic do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; the count alone decides which
  // slots are meaningful, and leaving the array off the reset tree lets it
  // map onto plain flops or a register file.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  // NOTE: every sequential assignment is non-blocking so all registers
  // update together from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bp_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// bp_resolve_ctrl: resolve/training sequencer for a tournament predictor.
//   pred_*    fetch-side prediction push (valid/ready), with the component
//             predictions and table index snapshots taken at predict time
//   res_*     execute-side resolution of the oldest in-flight branch
//   upd_*     one-cycle training write for local/global/choice tables
//   flush, redirect_pc   mispredict squash and fetch restart address
//   init_*    post-reset walk over every table index (clear to weakly-NT)
//   mis_cnt   saturating mispredict counter
//   res_err   sticky: a resolve arrived while nothing was in flight
// ---------------------------------------------------------------------------
module bp_resolve_ctrl
  import bp_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int LIDX_W = BP_LIDX_W,
  parameter int GIDX_W = BP_GIDX_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pred_valid,
  output logic              pred_ready,
  input  logic [31:0]       pred_pc,
  input  logic              pred_taken,
  input  logic              pred_local,
  input  logic              pred_global,
  input  logic [LIDX_W-1:0] pred_lidx,
  input  logic [GIDX_W-1:0] pred_gidx,
  input  logic [31:0]       pred_target,
  input  logic              res_valid,
  input  logic              res_taken,
  input  logic [31:0]       res_target,
  output logic              upd_valid,
  output logic              upd_taken,
  output logic [LIDX_W-1:0] upd_lidx,
  output logic [GIDX_W-1:0] upd_gidx,
  output logic              upd_local_ok,
  output logic              upd_global_ok,
  output logic              flush,
  output logic [31:0]       redirect_pc,
  output logic              init_we,
  output logic [GIDX_W-1:0] init_idx,
  output logic              init_busy,
  output logic [CNT_W-1:0]  mis_cnt,
  output logic              res_err
);

  // Entry layout follows the index widths of this instance.
  typedef struct packed {
    logic [31:0]       pc;
    logic              taken;
    logic              lpred;
    logic              gpred;
    logic [LIDX_W-1:0] lidx;
    logic [GIDX_W-1:0] gidx;
    logic [31:0]       target;
  } entry_t;

  bp_state_t state;
  entry_t    push_entry;
  entry_t    head;
  logic      q_full;
  logic      q_empty;
  logic      push;
  logic      pop;
  logic      mispredict;

  assign push_entry = '{pc:     pred_pc,
                        taken:  pred_taken,
                        lpred:  pred_local,
                        gpred:  pred_global,
                        lidx:   pred_lidx,
                        gidx:   pred_gidx,
                        target: pred_target};

  assign pred_ready = (state == RUN) && !q_full;
  assign init_busy  = (state == INIT);
  assign push       = pred_valid && pred_ready;
  assign pop        = (state == RUN) && res_valid && !q_empty;

  // A taken/taken pair still mispredicts when the fetched target was wrong.
  assign mispredict = pop && ((head.taken != res_taken) ||
                              (head.taken && res_taken && (head.target != res_target)));

  // Clearing on mispredict also drops a push accepted in the resolving cycle.
  bp_inflight_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (mispredict),
    .din   (push_entry),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= INIT;
      init_we       <= 1'b0;
      init_idx      <= '0;
      upd_valid     <= 1'b0;
      upd_taken     <= 1'b0;
      upd_lidx      <= '0;
      upd_gidx      <= '0;
      upd_local_ok  <= 1'b0;
      upd_global_ok <= 1'b0;
      flush         <= 1'b0;
      redirect_pc   <= '0;
      mis_cnt       <= '0;
      res_err       <= 1'b0;
    end else begin
      upd_valid <= 1'b0;
      flush     <= 1'b0;
      unique case (state)
        INIT: begin
          // First cycle out of reset arms the strobe at index 0; afterwards
          // the index advances once per strobed cycle.
          if (!init_we) begin
            init_we <= 1'b1;
          end else if (init_idx == '1) begin
            init_we  <= 1'b0;
            init_idx <= '0;
            state    <= RUN;
          end else begin
            init_idx <= init_idx + GIDX_W'(1);
          end
        end
        RUN: begin
          if (res_valid && q_empty) res_err <= 1'b1;
          if (pop) begin
            upd_valid     <= 1'b1;
            upd_taken     <= res_taken;
            upd_lidx      <= head.lidx;
            upd_gidx      <= head.gidx;
            upd_local_ok  <= (head.lpred == res_taken);
            upd_global_ok <= (head.gpred == res_taken);
          end
          if (mispredict) begin
            flush       <= 1'b1;
            redirect_pc <= res_taken ? res_target : seq_pc(head.pc);
            if (mis_cnt != '1) mis_cnt <= mis_cnt + CNT_W'(1);
            state       <= FLUSH;
          end
        end
        FLUSH: state <= RUN;
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bp_resolve_ctrl: directed bench for bp_resolve_ctrl. Inputs change 1 ns
// after the rising edge; outputs are sampled at the same point. The mispredict
// counter is built 2 bits wide so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_bp_resolve_ctrl;

  localparam int DEPTH  = 4;
  localparam int LIDX_W = 10;
  localparam int GIDX_W = 12;
  localparam int CNT_W  = 2;
  localparam int WALK   = 1 << GIDX_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pred_valid = 1'b0;
  logic              pred_ready;
  logic [31:0]       pred_pc = '0;
  logic              pred_taken = 1'b0;
  logic              pred_local = 1'b0;
  logic              pred_global = 1'b0;
  logic [LIDX_W-1:0] pred_lidx = '0;
  logic [GIDX_W-1:0] pred_gidx = '0;
  logic [31:0]       pred_target = '0;
  logic              res_valid = 1'b0;
  logic              res_taken = 1'b0;
  logic [31:0]       res_target = '0;
  logic              upd_valid;
  logic              upd_taken;
  logic [LIDX_W-1:0] upd_lidx;
  logic [GIDX_W-1:0] upd_gidx;
  logic              upd_local_ok;
  logic              upd_global_ok;
  logic              flush;
  logic [31:0]       redirect_pc;
  logic              init_we;
  logic [GIDX_W-1:0] init_idx;
  logic              init_busy;
  logic [CNT_W-1:0]  mis_cnt;
  logic              res_err;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  bp_resolve_ctrl #(
    .DEPTH (DEPTH), .LIDX_W (LIDX_W), .GIDX_W (GIDX_W), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .pred_valid (pred_valid), .pred_ready (pred_ready), .pred_pc (pred_pc),
    .pred_taken (pred_taken), .pred_local (pred_local), .pred_global (pred_global),
    .pred_lidx (pred_lidx), .pred_gidx (pred_gidx), .pred_target (pred_target),
    .res_valid (res_valid), .res_taken (res_taken), .res_target (res_target),
    .upd_valid (upd_valid), .upd_taken (upd_taken), .upd_lidx (upd_lidx),
    .upd_gidx (upd_gidx), .upd_local_ok (upd_local_ok), .upd_global_ok (upd_global_ok),
    .flush (flush), .redirect_pc (redirect_pc),
    .init_we (init_we), .init_idx (init_idx), .init_busy (init_busy),
    .mis_cnt (mis_cnt), .res_err (res_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pred(input logic [31:0] pc, input logic tk, input logic lp,
                          input logic gp, input logic [LIDX_W-1:0] li,
                          input logic [GIDX_W-1:0] gi, input logic [31:0] tgt);
    pred_valid  = 1'b1;
    pred_pc     = pc;
    pred_taken  = tk;
    pred_local  = lp;
    pred_global = gp;
    pred_lidx   = li;
    pred_gidx   = gi;
    pred_target = tgt;
  endtask

  // Called in the cycle right after reset release; leaves the DUT in RUN.
  task automatic walk_check(input string tag);
    int bad;
    bad = 0;
    check({tag, "_c0_we"}, init_we, 1'b0);
    check({tag, "_c0_busy"}, init_busy, 1'b1);
    tick();
    for (int i = 0; i < WALK; i++) begin
      if (init_we !== 1'b1 || init_idx !== i[GIDX_W-1:0] || init_busy !== 1'b1 ||
          pred_ready !== 1'b0 || upd_valid !== 1'b0 || flush !== 1'b0) bad++;
      tick();
    end
    check({tag, "_bad_cycles"}, bad, 0);
    check({tag, "_done_busy"}, init_busy, 1'b0);
    check({tag, "_done_we"}, init_we, 1'b0);
    check({tag, "_done_idx"}, init_idx, 0);
    check({tag, "_done_ready"}, pred_ready, 1'b1);
    check({tag, "_res_err"}, res_err, 1'b0);
  endtask

  initial begin
    logic [LIDX_W-1:0] drain_exp [4];
    drain_exp[0] = 10'h12;
    drain_exp[1] = 10'h13;
    drain_exp[2] = 10'h16;
    drain_exp[3] = 10'h17;

    // Reset values.
    #12;
    check("rst_busy", init_busy, 1'b1);
    check("rst_we", init_we, 1'b0);
    check("rst_idx", init_idx, 0);
    check("rst_ready", pred_ready, 1'b0);
    check("rst_upd", upd_valid, 1'b0);
    check("rst_flush", flush, 1'b0);
    check("rst_redirect", redirect_pc, 0);
    check("rst_mis", mis_cnt, 0);
    check("rst_err", res_err, 1'b0);
    #10 rst_n = 1'b1;

    // Init walk, with res_valid held high to show it is ignored.
    res_valid = 1'b1;
    walk_check("walk1");
    res_valid = 1'b0;

    // Correct not-taken resolve: training only.
    set_pred(32'h100, 1'b0, 1'b0, 1'b1, 10'h3A, 12'h5C3, 32'h0);
    tick();
    pred_valid = 1'b0;
    res_valid = 1'b1; res_taken = 1'b0; res_target = 32'h0;
    tick();
    res_valid = 1'b0;
    check("a_upd_valid", upd_valid, 1'b1);
    check("a_upd_lidx", upd_lidx, 10'h3A);
    check("a_upd_gidx", upd_gidx, 12'h5C3);
    check("a_upd_taken", upd_taken, 1'b0);
    check("a_local_ok", upd_local_ok, 1'b1);
    check("a_global_ok", upd_global_ok, 1'b0);
    check("a_flush", flush, 1'b0);
    tick();
    check("a_upd_pulse", upd_valid, 1'b0);

    // Predicted NT, actually taken -> redirect to resolved target.
    set_pred(32'h200, 1'b0, 1'b0, 1'b0, 10'h1, 12'h2, 32'h0);
    tick();
    pred_valid = 1'b0;
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h400;
    tick();
    res_valid = 1'b0;
    check("b_flush", flush, 1'b1);
    check("b_redirect", redirect_pc, 32'h400);
    check("b_mis", mis_cnt, 1);
    check("b_upd_valid", upd_valid, 1'b1);
    check("b_ready_flush", pred_ready, 1'b0);
    tick();
    check("b_flush_pulse", flush, 1'b0);
    check("b_ready_back", pred_ready, 1'b1);

    // Predicted taken, actually NT -> redirect to fall-through.
    set_pred(32'h200, 1'b1, 1'b1, 1'b1, 10'h1, 12'h2, 32'h300);
    tick();
    pred_valid = 1'b0;
    res_valid = 1'b1; res_taken = 1'b0; res_target = 32'h0;
    tick();
    res_valid = 1'b0;
    check("b2_flush", flush, 1'b1);
    check("b2_redirect", redirect_pc, 32'h204);
    check("b2_mis", mis_cnt, 2);
    tick();

    // Fill to DEPTH, then probe full behaviour and in-order draining.
    for (int i = 0; i < DEPTH; i++) begin
      check("c_ready_fill", pred_ready, 1'b1);
      set_pred(32'h1000 + 32'(i * 4), 1'b0, 1'b0, 1'b0, LIDX_W'(16 + i), 12'h0, 32'h0);
      tick();
    end
    check("c_full_ready", pred_ready, 1'b0);
    pred_lidx = 10'h14;                      // push attempt while full
    tick();
    check("c_still_full", pred_ready, 1'b0);
    pred_lidx = 10'h15;                      // push + pop while full: push lost
    res_valid = 1'b1; res_taken = 1'b0;
    tick();
    check("c_pop_full_lidx", upd_lidx, 10'h10);
    check("c_pop_full_ready", pred_ready, 1'b1);
    pred_lidx = 10'h16;                      // push + pop at 3 entries
    tick();
    res_valid = 1'b0;
    check("c_pp_lidx", upd_lidx, 10'h11);
    check("c_pp_ready", pred_ready, 1'b1);
    pred_lidx = 10'h17;
    tick();
    pred_valid = 1'b0;
    check("c_refull_ready", pred_ready, 1'b0);
    res_valid = 1'b1; res_taken = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      check("c_drain_valid", upd_valid, 1'b1);
      check("c_drain_lidx", upd_lidx, drain_exp[i]);
      check("c_drain_flush", flush, 1'b0);
    end
    res_valid = 1'b0;
    tick();
    check("c_empty_ready", pred_ready, 1'b1);
    check("c_mis_hold", mis_cnt, 2);

    // Taken/taken with wrong target; same-cycle push must be discarded.
    set_pred(32'h600, 1'b1, 1'b1, 1'b0, 10'h20, 12'h21, 32'h500);
    tick();
    set_pred(32'h700, 1'b0, 1'b0, 1'b0, 10'h30, 12'h31, 32'h0);
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h504;
    check("d_ready_same", pred_ready, 1'b1);
    tick();
    pred_valid = 1'b0; res_valid = 1'b0;
    check("d_flush", flush, 1'b1);
    check("d_redirect", redirect_pc, 32'h504);
    check("d_mis", mis_cnt, 3);
    check("d_upd_lidx", upd_lidx, 10'h20);
    check("d_local_ok", upd_local_ok, 1'b1);
    check("d_global_ok", upd_global_ok, 1'b0);
    tick();
    res_valid = 1'b1; res_taken = 1'b0;
    tick();
    res_valid = 1'b0;
    check("d_res_err", res_err, 1'b1);
    check("d_no_upd", upd_valid, 1'b0);
    check("d_no_flush", flush, 1'b0);

    // Counter saturates at all-ones.
    set_pred(32'h800, 1'b0, 1'b0, 1'b0, 10'h0, 12'h0, 32'h0);
    tick();
    pred_valid = 1'b0;
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h900;
    tick();
    res_valid = 1'b0;
    check("e_flush", flush, 1'b1);
    check("e_redirect", redirect_pc, 32'h900);
    check("e_mis_sat", mis_cnt, 3);
    tick();

    // Reset with three entries in flight.
    for (int i = 0; i < 3; i++) begin
      set_pred(32'hA00 + 32'(i * 4), 1'b0, 1'b0, 1'b0, LIDX_W'(i), 12'h0, 32'h0);
      tick();
    end
    pred_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("f_rst_busy", init_busy, 1'b1);
    check("f_rst_we", init_we, 1'b0);
    check("f_rst_idx", init_idx, 0);
    check("f_rst_ready", pred_ready, 1'b0);
    check("f_rst_mis", mis_cnt, 0);
    check("f_rst_err", res_err, 1'b0);
    check("f_rst_redirect", redirect_pc, 0);
    #10 rst_n = 1'b1;
    walk_check("walk2");
    res_valid = 1'b1; res_taken = 1'b0;
    tick();
    res_valid = 1'b0;
    check("f_res_err", res_err, 1'b1);
    check("f_no_upd", upd_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
